// File: rtl/gpio_arb_pkg.sv
// Shared types and helpers for the GPIO output arbiter and its round-robin picker.
package gpio_arb_pkg;

    // Largest requester count any arbiter built on the picker supports.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    // Default hold length and the counter width it needs (counts HOLD_CYCLES-1 down to 0).
    localparam int DEFAULT_HOLD_CYCLES = 16;
    localparam int HOLD_CNT_W          = $clog2(DEFAULT_HOLD_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Winner is the first set request bit after 'last', wrapping modulo num_req.
    // Returns 0 when nothing is requested; callers qualify it with |req.
    function automatic logic [MAX_IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] last,
        input int                   num_req
    );
        int   cand;
        logic found;
        rr_next = '0;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (!found && (k <= num_req)) begin
                cand = (int'(last) + k) % num_req;
                if (req[cand[MAX_IDX_W-1:0]]) begin
                    rr_next = cand[MAX_IDX_W-1:0];
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/gpio_rr_picker.sv
// Combinational round-robin picker; reusable by any shared-resource arbiter.
module gpio_rr_picker
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [MAX_REQ-1:0]   req_pad;
    logic [MAX_IDX_W-1:0] last_pad;
    logic [MAX_IDX_W-1:0] pick;

    // Widen to the package's fixed width, search, and narrow the result back.
    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = req;
        last_pad               = '0;
        last_pad[IDX_W-1:0]    = last;
        pick                   = rr_next(req_pad, last_pad, NUM_REQ);
        grant_valid            = |req;
        grant_idx              = pick[IDX_W-1:0];
    end

endmodule

// File: rtl/gpio_output_arbiter.sv
// Shares the GPIO output bank between requesters: round-robin grant, masked
// read-modify-write per grant, then a fixed hold so output states stay visible.
module gpio_output_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int                    NUM_REQ     = 4,
    parameter int                    GPIO_WIDTH  = 8,
    parameter int                    HOLD_CYCLES = 16,
    parameter logic [GPIO_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*GPIO_WIDTH-1:0] wdata,
    input  logic [NUM_REQ*GPIO_WIDTH-1:0] wmask,
    output logic [NUM_REQ-1:0]            ack,
    output logic [GPIO_WIDTH-1:0]         gpio_o,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("gpio_output_arbiter: NUM_REQ must be in 2..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("gpio_output_arbiter: HOLD_CYCLES must be >= 1");
    end

    arb_state_t             state_reg;
    logic [GPIO_WIDTH-1:0]  gpio_reg;
    logic [NUM_REQ-1:0]     ack_reg;
    logic                   busy_reg;
    logic [IDX_W-1:0]       owner_reg;
    logic [IDX_W-1:0]       last_reg;
    logic [CNT_W-1:0]       cnt_reg;

    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;

    logic [GPIO_WIDTH-1:0]  wdata_arr  [NUM_REQ];
    logic [GPIO_WIDTH-1:0]  wmask_arr  [NUM_REQ];
    logic [GPIO_WIDTH-1:0]  merged_arr [NUM_REQ];

    // Per-requester slices and the value gpio_o would take if that requester won.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign wdata_arr[gi]  = wdata[gi*GPIO_WIDTH +: GPIO_WIDTH];
        assign wmask_arr[gi]  = wmask[gi*GPIO_WIDTH +: GPIO_WIDTH];
        assign merged_arr[gi] = (gpio_reg & ~wmask_arr[gi]) | (wdata_arr[gi] & wmask_arr[gi]);
    end

    gpio_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (req),
        .last        (last_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Arbiter FSM: grant and apply one write from IDLE, then sit in HOLD for HOLD_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            gpio_reg  <= RESET_VALUE;
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
            owner_reg <= '0;
            last_reg  <= IDX_W'(NUM_REQ - 1);
            cnt_reg   <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        gpio_reg           <= merged_arr[grant_idx];
                        ack_reg[grant_idx] <= 1'b1;
                        owner_reg          <= grant_idx;
                        last_reg           <= grant_idx;
                        cnt_reg            <= CNT_W'(HOLD_CYCLES - 1);
                        busy_reg           <= 1'b1;
                        state_reg          <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack    = ack_reg;
    assign gpio_o = gpio_reg;
    assign busy   = busy_reg;
    assign owner  = owner_reg;

endmodule

// File: tb/tb_gpio_output_arbiter.sv
// Directed bench for gpio_output_arbiter: vector table plus multi-cycle sequences.
module tb_gpio_output_arbiter;

    localparam int         NR = 4;
    localparam int         GW = 8;
    localparam int         HC = 16;
    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [3:0]  ack;
    logic [7:0]  gpio_o;
    logic        busy;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    gpio_output_arbiter #(
        .NUM_REQ     (NR),
        .GPIO_WIDTH  (GW),
        .HOLD_CYCLES (HC),
        .RESET_VALUE (RV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .wdata   (wdata),
        .wmask   (wmask),
        .ack     (ack),
        .gpio_o  (gpio_o),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [7:0]  exp_gpio;
        logic [3:0]  exp_ack;
        logic [1:0]  exp_owner;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge where ack was seen: ack must clear, busy must last HC cycles.
    task automatic count_hold(input logic [7:0] exp_gpio);
        int n;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) check("ack_one_cycle", 32'(ack), 32'h0);
            if (busy) n++;
            else break;
        end
        check("busy_length", 32'(n), 32'(HC));
        check("gpio_after_hold", 32'(gpio_o), 32'(exp_gpio));
    endtask

    task automatic wait_ack(input string name, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (ack == 4'b0 && waited < 60);
        if (ack == 4'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no ack within 60 cycles", name);
        end
    endtask

    initial begin
        int         waited;
        int         prev_cyc;
        logic       seen_ack;

        vecs[0] = '{4'b0001, {8'h11, 8'h22, 8'h33, 8'h00}, 32'hFFFF_FFFF,               8'h00, 4'b0001, 2'd0};
        vecs[1] = '{4'b0100, {8'h00, 8'hFF, 8'h00, 8'h00}, {8'hFF, 8'h0F, 8'hFF, 8'hFF}, 8'h0F, 4'b0100, 2'd2};
        vecs[2] = '{4'b0011, {8'h00, 8'h00, 8'h00, 8'hF0}, {8'h00, 8'h00, 8'hFF, 8'hF0}, 8'hFF, 4'b0001, 2'd0};
        vecs[3] = '{4'b0011, {8'hFF, 8'hFF, 8'h00, 8'hFF}, {8'hFF, 8'hFF, 8'h81, 8'hFF}, 8'h7E, 4'b0010, 2'd1};
        vecs[4] = '{4'b1001, {8'hAA, 8'h00, 8'h00, 8'h00}, {8'hFF, 8'h00, 8'h00, 8'hFF}, 8'hAA, 4'b1000, 2'd3};
        vecs[5] = '{4'b1001, {8'h00, 8'h00, 8'h00, 8'h55}, {8'hFF, 8'h00, 8'h00, 8'h0F}, 8'hA5, 4'b0001, 2'd0};
        vecs[6] = '{4'b1000, 32'hFFFF_FFFF,               32'h0,                        8'hA5, 4'b1000, 2'd3};
        vecs[7] = '{4'b1110, {8'h00, 8'h00, 8'h3C, 8'h00}, 32'hFFFF_FFFF,               8'h3C, 4'b0010, 2'd1};
        vecs[8] = '{4'b1100, {8'hFF, 8'h12, 8'h00, 8'h00}, {8'hFF, 8'hF0, 8'h00, 8'h00}, 8'h1C, 4'b0100, 2'd2};

        // Reset value during and after reset
        reset_n = 1'b0;
        req     = '0;
        wdata   = '0;
        wmask   = '0;
        @(posedge clk);
        #1;
        check("rst_gpio", 32'(gpio_o), 32'(RV));
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_gpio", 32'(gpio_o), 32'(RV));
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_ack", 32'(ack), 32'h0);
        $display("reset: gpio=%h busy=%b ack=%b", gpio_o, busy, ack);

        // Table of single updates, each followed by the full hold
        for (int v = 0; v < 9; v++) begin
            req   = vecs[v].req;
            wdata = vecs[v].wdata;
            wmask = vecs[v].wmask;
            @(negedge clk);
            check("vec_ack", 32'(ack), 32'(vecs[v].exp_ack));
            check("vec_gpio", 32'(gpio_o), 32'(vecs[v].exp_gpio));
            check("vec_owner", 32'(owner), 32'(vecs[v].exp_owner));
            check("vec_busy", 32'(busy), 32'h1);
            $display("vec %0d: req=%b ack=%b gpio=%h owner=%0d", v, vecs[v].req, ack, gpio_o, owner);
            req = '0;
            count_hold(vecs[v].exp_gpio);
        end

        // Round-robin over all four with 1+HC spacing, starting from a fresh pointer
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req      = 4'b1111;
        wdata    = {8'h04, 8'h03, 8'h02, 8'h01};
        wmask    = 32'hFFFF_FFFF;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("rr_wait", waited);
            if (k == 0) check("rr_latency", 32'(waited), 32'h1);
            else        check("rr_spacing", 32'(cyc - prev_cyc), 32'(HC + 1));
            prev_cyc = cyc;
            check("rr_ack", 32'(ack), 32'(4'b0001 << k));
            check("rr_gpio", 32'(gpio_o), 32'(k + 1));
            check("rr_owner", 32'(owner), 32'(k));
            $display("rr grant %0d: ack=%b gpio=%h owner=%0d", k, ack, gpio_o, owner);
            req[k] = 1'b0;
        end
        count_hold(8'h04);

        // Asynchronous reset five cycles into HOLD, then re-grant with requester 0 first
        req   = 4'b0010;
        wdata = {8'h00, 8'h00, 8'h3C, 8'h81};
        wmask = 32'hFFFF_FFFF;
        @(negedge clk);
        check("mid_ack", 32'(ack), 32'h2);
        check("mid_gpio", 32'(gpio_o), 32'h3C);
        check("mid_owner", 32'(owner), 32'h1);
        req = 4'b0011;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_gpio", 32'(gpio_o), 32'(RV));
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_owner", 32'(owner), 32'h0);
        $display("async reset: gpio=%h busy=%b", gpio_o, busy);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("regrant0_ack", 32'(ack), 32'h1);
        check("regrant0_gpio", 32'(gpio_o), 32'h81);
        $display("regrant: ack=%b gpio=%h owner=%0d", ack, gpio_o, owner);
        req[0] = 1'b0;
        count_hold(8'h81);
        @(negedge clk);
        check("regrant1_ack", 32'(ack), 32'h2);
        check("regrant1_gpio", 32'(gpio_o), 32'h3C);
        check("regrant1_owner", 32'(owner), 32'h1);
        $display("regrant: ack=%b gpio=%h owner=%0d", ack, gpio_o, owner);
        req = '0;
        count_hold(8'h3C);

        // Withdrawn request during HOLD earns nothing
        req   = 4'b0001;
        wdata = {8'h77, 8'h77, 8'h77, 8'hFF};
        wmask = {8'hFF, 8'hFF, 8'hFF, 8'h03};
        @(negedge clk);
        check("wd_ack", 32'(ack), 32'h1);
        check("wd_gpio", 32'(gpio_o), 32'h3F);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        req      = 4'b0000;
        seen_ack = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack != 4'b0) seen_ack = 1'b1;
        end
        check("wd_no_ack", 32'(seen_ack), 32'h0);
        check("wd_gpio_kept", 32'(gpio_o), 32'h3F);
        check("wd_idle", 32'(busy), 32'h0);
        $display("withdrawn: seen_ack=%b gpio=%h", seen_ack, gpio_o);

        // Zero-mask write: acked, no change, still holds
        req   = 4'b0100;
        wdata = 32'hFFFF_FFFF;
        wmask = 32'h0;
        @(negedge clk);
        check("zm_ack", 32'(ack), 32'h4);
        check("zm_gpio", 32'(gpio_o), 32'h3F);
        check("zm_busy", 32'(busy), 32'h1);
        check("zm_owner", 32'(owner), 32'h2);
        $display("zero mask: ack=%b gpio=%h busy=%b", ack, gpio_o, busy);
        req = '0;
        count_hold(8'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
